act_lut_loader: RTL and testbench

- Runtime writer for the activation lookup table: accepts a stream of fixed-point table entries over valid/ready and writes them into an on-chip table RAM (M20K-sized, SAMPLES x DW).
- Exposes a registered lookup read port with the same 2-cycle address-to-data latency as the activation evaluators, so a table-driven activation block can read the table this block writes.
- Sits between the instruction/data loader and the activation units, replacing a fixed init-file ROM with a reloadable table.

---
 rtl/act_lut_loader.sv | 143 ++++++++++++++
 tb/tb_act_lut_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_lut_loader.sv
// Reloadable activation lookup table: streams entries into an inferred block RAM
// and serves a 2-cycle registered lookup port to the activation units.
module act_lut_loader #(
    parameter int DW      = 32,
    parameter int SAMPLES = 512,
    parameter int AW      = $clog2(SAMPLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic [AW:0]   load_count,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum,
    output logic          table_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    localparam logic [AW:0]   SAMPLES_W = (AW+1)'(SAMPLES);
    localparam logic [AW:0]   ONE_W     = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] checksum_q, checksum_d;
    logic          table_valid_q, table_valid_d;
    logic          in_ready_q;
    logic          wr_en;
    logic [AW:0]   count_clamped;

    logic [DW-1:0] table_mem [SAMPLES];
    logic [DW-1:0] ram_rd_q;
    logic          rd_en_q;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;

    assign count_clamped = (load_count > SAMPLES_W) ? SAMPLES_W : load_count;
    // in_ready_q is only ever high while in LOAD, so it doubles as the write qualifier.
    assign wr_en         = in_valid && in_ready_q;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        checksum_d    = checksum_q;
        table_valid_d = table_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    count_d       = count_clamped;
                    wr_ptr_d      = '0;
                    checksum_d    = '0;
                    table_valid_d = 1'b0;
                    state_d       = (count_clamped == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (wr_en) begin
                    checksum_d = checksum_q + in_data;
                    // Pointer parks on the last entry instead of wrapping past count-1.
                    if ({1'b0, wr_ptr_q} == count_q - ONE_W) begin
                        state_d = ST_DONE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_DONE) begin
            table_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            checksum_q    <= '0;
            table_valid_q <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            checksum_q    <= checksum_d;
            table_valid_q <= table_valid_d;
            in_ready_q    <= (state_d == ST_LOAD);
        end
    end

    // Read-before-write: a same-cycle read of the written address returns old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[wr_ptr_q] <= in_data;
        end
        if (rd_en) begin
            ram_rd_q <= table_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_en_q    <= rd_en;
            rd_valid_q <= rd_en_q;
            if (rd_en_q) begin
                rd_data_q <= ram_rd_q;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = (state_q == ST_LOAD);
    assign done        = (state_q == ST_DONE);
    assign checksum    = checksum_q;
    assign table_valid = table_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_act_lut_loader.sv
// Bench for act_lut_loader: scenario tasks drive loads and reads; read results are
// checked against a queue of values predicted from a shadow copy of the table.
module tb_act_lut_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [9:0]  load_count;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [31:0] checksum;
    logic        table_valid;

    int          checks;
    int          errors;
    logic [31:0] model_mem [512];
    logic [31:0] stim [600];
    logic [31:0] exp_q [$];
    logic [31:0] last_exp;

    act_lut_loader #(.DW(32), .SAMPLES(512)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_count  (load_count),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done),
        .checksum    (checksum),
        .table_valid (table_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; sample 1 time unit after the edge and score any read result.
    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid=1 rd_data=%h, required no read outstanding", rd_data);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %h required %h", rd_data, e);
                end else begin
                    $display("read  data=%h", rd_data);
                end
            end
        end
    endtask

    task automatic do_reads(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            rd_en   = 1'b1;
            rd_addr = 9'(first + i);
            exp_q.push_back(model_mem[first + i]);
            tick();
        end
        rd_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_drain: outstanding=%0d rd_valid=%b, required 0 and 0", exp_q.size(), rd_valid);
        end
        tick();
        checks++;
        if (rd_data !== last_exp) begin
            errors++;
            $display("FAIL rd_hold: rd_data=%h required %h", rd_data, last_exp);
        end
    endtask

    task automatic do_load(input int cnt, input bit toggle_mode, input int restart_at, input int probe_addr);
        int          eff;
        int          accepted;
        int          cycles;
        int          budget;
        bit          tog;
        bit          restarted;
        bit          probe_next;
        bit          accept;
        logic [31:0] sum;
        eff        = (cnt > 512) ? 512 : cnt;
        sum        = '0;
        accepted   = 0;
        cycles     = 0;
        tog        = 1'b1;
        restarted  = 1'b0;
        probe_next = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_start: in_ready=%b busy=%b required 0 0", in_ready, busy);
        end
        load_start = 1'b1;
        load_count = 10'(cnt);
        tick();
        load_start = 1'b0;
        if (eff > 0) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b1 || table_valid !== 1'b0) begin
                errors++;
                $display("FAIL load_entry: busy=%b in_ready=%b table_valid=%b required 1 1 0",
                         busy, in_ready, table_valid);
            end
        end
        budget = 4 * eff + 20;
        while (accepted < eff && cycles < budget) begin
            in_valid   = toggle_mode ? tog : 1'b1;
            in_data    = stim[accepted];
            rd_en      = 1'b0;
            load_start = 1'b0;
            if (restart_at >= 0 && !restarted && accepted == restart_at) begin
                load_start = 1'b1;
                load_count = 10'd2;
                restarted  = 1'b1;
            end
            accept = in_valid && (in_ready === 1'b1);
            if (probe_next) begin
                rd_en      = 1'b1;
                rd_addr    = 9'(probe_addr);
                exp_q.push_back(model_mem[probe_addr]);
                probe_next = 1'b0;
            end else if (accept && accepted == probe_addr) begin
                rd_en      = 1'b1;
                rd_addr    = 9'(probe_addr);
                exp_q.push_back(model_mem[probe_addr]);
                probe_next = 1'b1;
            end
            if (accept) begin
                model_mem[accepted] = stim[accepted];
                sum = sum + stim[accepted];
                accepted++;
            end
            tick();
            cycles++;
            tog = !tog;
            checks++;
            if (checksum !== sum) begin
                errors++;
                $display("FAIL checksum_run: beat %0d checksum=%h required %h", accepted, checksum, sum);
            end
        end
        in_valid   = 1'b0;
        rd_en      = 1'b0;
        load_start = 1'b0;
        if (accepted < eff) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: accepted %0d beats, required %0d", accepted, eff);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || table_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_state: done=%b busy=%b in_ready=%b table_valid=%b required 1 0 0 1",
                     done, busy, in_ready, table_valid);
        end
        checks++;
        if (checksum !== sum) begin
            errors++;
            $display("FAIL checksum_done: checksum=%h required %h", checksum, sum);
        end
        if (!toggle_mode) begin
            checks++;
            if (cycles != eff) begin
                errors++;
                $display("FAIL load_cycles: %0d cycles for back-to-back load, required %0d", cycles, eff);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || table_valid !== 1'b1 || checksum !== sum) begin
            errors++;
            $display("FAIL after_done: done=%b table_valid=%b checksum=%h required 0 1 %h",
                     done, table_valid, checksum, sum);
        end
        $display("load  count=%0d beats=%0d checksum=%h", cnt, accepted, checksum);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        load_start = 1'b0;
        load_count = '0;
        in_data    = '0;
        in_valid   = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        last_exp   = '0;
        #2;
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 ||
            rd_data !== 32'h0 || checksum !== 32'h0 || table_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b busy=%b done=%b rv=%b rd=%h cs=%h tv=%b required all 0",
                     in_ready, busy, done, rd_valid, rd_data, checksum, table_valid);
        end
        rst = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_load_b2b();
        for (int i = 0; i < 4; i++) stim[i] = 32'((i + 1) * 16);
        do_load(4, 1'b0, -1, -1);
        checks++;
        if (checksum !== 32'h000000A0) begin
            errors++;
            $display("FAIL b2b_checksum: checksum=%h required 000000a0", checksum);
        end
        do_reads(0, 4);
    endtask

    task automatic test_load_toggle();
        for (int i = 0; i < 4; i++) stim[i] = 32'((i + 1) * 16);
        model_mem[0] = 32'hFFFF_FFFF;
        do_load(4, 1'b1, -1, -1);
        checks++;
        if (checksum !== 32'h000000A0) begin
            errors++;
            $display("FAIL toggle_checksum: checksum=%h required 000000a0", checksum);
        end
        do_reads(0, 4);
    endtask

    task automatic test_count_zero();
        do_load(0, 1'b0, -1, -1);
        do_reads(0, 4);
    endtask

    task automatic test_count_clamp();
        for (int i = 0; i < 600; i++) stim[i] = $urandom;
        do_load(600, 1'b0, -1, -1);
        do_reads(0, 4);
        do_reads(508, 4);
    endtask

    task automatic test_restart_ignored();
        for (int i = 0; i < 4; i++) stim[i] = 32'h0100_0000 + 32'(i * 3);
        do_load(4, 1'b0, 2, -1);
        do_reads(0, 4);
    endtask

    task automatic test_read_during_write();
        for (int i = 0; i < 8; i++) stim[i] = 32'h1111_1111;
        do_load(8, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) stim[i] = $urandom;
        stim[5] = 32'hDEAD_BEEF;
        do_load(8, 1'b0, -1, 5);
        do_reads(4, 3);
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 8; i++) stim[i] = $urandom;
        load_start = 1'b1;
        load_count = 10'd8;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = stim[i];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL midload_ready: beat %0d in_ready=%b required 1", i, in_ready);
            end else begin
                model_mem[i] = stim[i];
            end
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || table_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 ||
            checksum !== 32'h0) begin
            errors++;
            $display("FAIL midload_reset: busy=%b tv=%b rdy=%b done=%b cs=%h required 0 0 0 0 0",
                     busy, table_valid, in_ready, done, checksum);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        $display("reset mid-load after 3 beats");
        for (int i = 0; i < 8; i++) stim[i] = $urandom;
        do_load(8, 1'b0, -1, -1);
        do_reads(0, 8);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_b2b();
        test_load_toggle();
        test_count_zero();
        test_count_clamp();
        test_restart_ignored();
        test_read_during_write();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
